// File: rtl/frag_tx_arbiter.sv
// -----------------------------------------------------------------------------
// frag_tx_arbiter
//
// Shares the Aurora TX fragment FIFO between NUM_SRC router segmenter lanes
// and one ACK generator. Every granted fragment is one AURORA_WIDTH word with
// header [1:0] src, [3:2] dst, [6:4] fragment number, [8:7] reserved.
//
// With LOCK_PKT=1 the grant is held on one source from fragment 0 up to the
// last fragment, so a packet stays contiguous on the link. ACKs may interleave
// only while the locked source has nothing to offer. Fragment-number ordering
// is checked on every accepted data fragment.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-source fragment valid
//   req_frag        per-source fragment, source i at [i*AURORA_WIDTH +: AURORA_WIDTH]
//   req_ready       per-source accept (combinational, at most one bit set)
//   ack_valid       ACK fragment valid
//   ack_frag        ACK fragment
//   ack_ready       ACK accept (combinational)
//   full_tx_fifo    TX FIFO full; blocks every accept
//   wr_tx_fifo      TX FIFO write strobe (registered, one cycle after accept)
//   frag_tx         fragment written to the TX FIFO (registered, holds value)
//   grant_id        source of the last written data fragment (registered)
//   locked          packet lock held (registered)
//   err_frag_seq    one-cycle pulse, aligned with wr_tx_fifo, on order violation
// -----------------------------------------------------------------------------
module frag_tx_arbiter #(
    parameter int AURORA_WIDTH = 256,
    parameter int NUM_SRC      = 4,
    parameter int SRC_ID_WIDTH = 2,
    parameter int NUMBER_FRAG  = 5,
    parameter bit LOCK_PKT     = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC-1:0]                req_valid,
    input  logic [NUM_SRC*AURORA_WIDTH-1:0]   req_frag,
    output logic [NUM_SRC-1:0]                req_ready,
    input  logic                              ack_valid,
    input  logic [AURORA_WIDTH-1:0]           ack_frag,
    output logic                              ack_ready,
    input  logic                              full_tx_fifo,
    output logic                              wr_tx_fifo,
    output logic [AURORA_WIDTH-1:0]           frag_tx,
    output logic [SRC_ID_WIDTH-1:0]           grant_id,
    output logic                              locked,
    output logic                              err_frag_seq
);

    localparam int                FNUM_W    = 3;
    localparam logic [FNUM_W-1:0] LAST_FNUM = FNUM_W'(NUMBER_FRAG - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                  state_r;
    logic [SRC_ID_WIDTH-1:0] ptr_r;
    logic [SRC_ID_WIDTH-1:0] lock_id_r;
    logic [FNUM_W-1:0]       exp_frag_r;
    // Per-source expectation, only meaningful when packets are not locked.
    logic [FNUM_W-1:0]       exp_cnt_r [NUM_SRC];

    logic [SRC_ID_WIDTH-1:0] rr_id_s;
    logic                    rr_found_s;
    logic [NUM_SRC-1:0]      req_ready_s;
    logic                    ack_ready_s;
    logic [SRC_ID_WIDTH-1:0] data_id_s;
    logic                    data_acc_s;
    logic                    ack_acc_s;
    logic [AURORA_WIDTH-1:0] data_word_s;
    logic [FNUM_W-1:0]       fnum_s;
    logic                    is_last_s;
    logic [FNUM_W-1:0]       exp_s;
    logic [FNUM_W-1:0]       next_exp_s;

    // Round-robin search starting just after the pointer. The loop runs from
    // the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        logic [SRC_ID_WIDTH-1:0] cand_v;
        rr_id_s    = ptr_r;
        rr_found_s = 1'b0;
        cand_v     = ptr_r;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_v     = SRC_ID_WIDTH'(ptr_r + SRC_ID_WIDTH'(k));
            rr_found_s = rr_found_s | req_valid[cand_v];
            rr_id_s    = req_valid[cand_v] ? cand_v : rr_id_s;
        end
    end

    // Ready generation: FIFO full blocks everything, a held lock serves only
    // its owner (ACK fills the gaps), otherwise ACK has strict priority.
    always_comb begin
        req_ready_s = '0;
        ack_ready_s = 1'b0;
        if (full_tx_fifo) begin
            req_ready_s = '0;
            ack_ready_s = 1'b0;
        end else if (state_r == ST_LOCKED) begin
            if (req_valid[lock_id_r]) begin
                req_ready_s[lock_id_r] = 1'b1;
            end else begin
                ack_ready_s = 1'b1;
            end
        end else if (ack_valid) begin
            ack_ready_s = 1'b1;
        end else if (rr_found_s) begin
            req_ready_s[rr_id_s] = 1'b1;
        end else begin
            req_ready_s = '0;
            ack_ready_s = 1'b0;
        end
    end

    assign req_ready = req_ready_s;
    assign ack_ready = ack_ready_s;

    assign data_id_s   = (state_r == ST_LOCKED) ? lock_id_r : rr_id_s;
    assign data_acc_s  = |(req_valid & req_ready_s);
    assign ack_acc_s   = ack_valid & ack_ready_s;
    assign data_word_s = req_frag[data_id_s*AURORA_WIDTH +: AURORA_WIDTH];
    assign fnum_s      = data_word_s[6:4];
    // Out-of-range fragment numbers are treated as the end of the packet.
    assign is_last_s   = (fnum_s >= LAST_FNUM);
    assign exp_s       = LOCK_PKT ? ((state_r == ST_LOCKED) ? exp_frag_r : 3'd0)
                                  : exp_cnt_r[data_id_s];
    // Expectation resynchronises to the number actually received, so a single
    // gap in the sequence produces a single error pulse.
    assign next_exp_s  = is_last_s ? 3'd0 : (fnum_s + 3'd1);

    // Lock FSM, round-robin pointer, order tracking and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_UNLOCKED;
            ptr_r        <= SRC_ID_WIDTH'(NUM_SRC - 1);
            lock_id_r    <= '0;
            exp_frag_r   <= 3'd0;
            for (int i = 0; i < NUM_SRC; i++) begin
                exp_cnt_r[i] <= 3'd0;
            end
            wr_tx_fifo   <= 1'b0;
            frag_tx      <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            err_frag_seq <= 1'b0;
        end else begin
            wr_tx_fifo   <= data_acc_s | ack_acc_s;
            err_frag_seq <= data_acc_s & (fnum_s != exp_s);
            if (data_acc_s) begin
                frag_tx              <= data_word_s;
                ptr_r                <= data_id_s;
                grant_id             <= data_id_s;
                exp_cnt_r[data_id_s] <= next_exp_s;
                if (LOCK_PKT && !is_last_s) begin
                    state_r    <= ST_LOCKED;
                    lock_id_r  <= data_id_s;
                    exp_frag_r <= next_exp_s;
                    locked     <= 1'b1;
                end else begin
                    state_r    <= ST_UNLOCKED;
                    exp_frag_r <= 3'd0;
                    locked     <= 1'b0;
                end
            end else if (ack_acc_s) begin
                frag_tx <= ack_frag;
            end else begin
                frag_tx <= frag_tx;
            end
        end
    end

endmodule

// File: tb/tb_frag_tx_arbiter.sv
module tb_frag_tx_arbiter;

    localparam int W   = 256;
    localparam int NS  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS-1:0]   req_valid;
    logic [NS*W-1:0] req_frag;
    logic [NS-1:0]   req_ready;
    logic            ack_valid;
    logic [W-1:0]    ack_frag;
    logic            ack_ready;
    logic            full_tx_fifo;
    logic            wr_tx_fifo;
    logic [W-1:0]    frag_tx;
    logic [IDW-1:0]  grant_id;
    logic            locked;
    logic            err_frag_seq;

    always #5 clk = ~clk;

    frag_tx_arbiter #(
        .AURORA_WIDTH(W), .NUM_SRC(NS), .SRC_ID_WIDTH(IDW),
        .NUMBER_FRAG(5), .LOCK_PKT(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_frag(req_frag), .req_ready(req_ready),
        .ack_valid(ack_valid), .ack_frag(ack_frag), .ack_ready(ack_ready),
        .full_tx_fifo(full_tx_fifo), .wr_tx_fifo(wr_tx_fifo), .frag_tx(frag_tx),
        .grant_id(grant_id), .locked(locked), .err_frag_seq(err_frag_seq)
    );

    typedef struct {
        logic [W-1:0]   frag;
        logic           err;
        logic           lk;
        logic [IDW-1:0] gid;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] sq [NS][$];
    logic [W-1:0] aq [$];
    logic [NS-1:0] src_en;
    logic         full_r;
    logic         prev_hs;
    int           n_test = 0;
    int           n_fail = 0;
    int           tag    = 1;

    function automatic logic [W-1:0] mk(input int src, input int dst, input int fnum, input int t);
        logic [W-1:0] f;
        f = '0;
        f[1:0]     = src[1:0];
        f[3:2]     = dst[1:0];
        f[6:4]     = fnum[2:0];
        f[40:9]    = ~t;
        f[255:224] = t;
        return f;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_test++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic add_data(input int s, input int fnum, input logic err, input logic lk);
        exp_t e;
        e.frag = mk(s, (s + 1) % NS, fnum, tag);
        e.err  = err;
        e.lk   = lk;
        e.gid  = s[IDW-1:0];
        tag++;
        sq[s].push_back(e.frag);
        exp_q.push_back(e);
    endtask

    task automatic add_ack(input logic lk, input logic [IDW-1:0] gid);
        exp_t e;
        e.frag = mk(0, 0, 0, 32'h4143_0000 + tag);
        e.err  = 1'b0;
        e.lk   = lk;
        e.gid  = gid;
        tag++;
        aq.push_back(e.frag);
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            req_valid[s]       = src_en[s] && (sq[s].size() > 0);
            req_frag[s*W +: W] = (sq[s].size() > 0) ? sq[s][0] : '0;
        end
        ack_valid    = (aq.size() > 0);
        ack_frag     = (aq.size() > 0) ? aq[0] : '0;
        full_tx_fifo = full_r;
    endtask

    task automatic step();
        exp_t e;
        logic hs;
        drive();
        @(negedge clk);
        chk("wr_strobe", wr_tx_fifo, prev_hs);
        chk("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
        if (full_r) chk("stall_ready", {req_ready, ack_ready}, '0);
        if (wr_tx_fifo) begin
            if (exp_q.size() == 0) begin
                n_test++;
                n_fail++;
                $error("FAIL spurious_write: got frag %h expected no write", frag_tx);
            end else begin
                e = exp_q.pop_front();
                chk("frag_tx", frag_tx, e.frag);
                chk("err_frag_seq", err_frag_seq, e.err);
                chk("locked", locked, e.lk);
                chk("grant_id", grant_id, e.gid);
            end
        end
        hs = (|(req_valid & req_ready)) | (ack_valid & ack_ready);
        for (int s = 0; s < NS; s++) begin
            if (req_valid[s] && req_ready[s]) void'(sq[s].pop_front());
        end
        if (ack_valid && ack_ready) void'(aq.pop_front());
        prev_hs = hs;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        n_test++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout: got %0d pending writes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        src_en       = '1;
        full_r       = 1'b0;
        prev_hs      = 1'b0;
        req_valid    = '0;
        req_frag     = '0;
        ack_valid    = 1'b0;
        ack_frag     = '0;
        full_tx_fifo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", wr_tx_fifo, 1'b0);
        chk("rst_frag", frag_tx, '0);
        chk("rst_gid", grant_id, 2'd0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_err", err_frag_seq, 1'b0);
        rst_n = 1'b1;

        // Two full packets: source 0 first, then source 2, each contiguous.
        for (int f = 0; f < 5; f++) add_data(0, f, 1'b0, f < 4);
        for (int f = 0; f < 5; f++) add_data(2, f, 1'b0, f < 4);
        drain(40);

        // ACK and source 1 together while unlocked: ACK first.
        add_ack(1'b0, 2'd2);
        for (int f = 0; f < 5; f++) add_data(1, f, 1'b0, f < 4);
        drain(40);

        // Fragment 2 skipped: one error pulse on fnum 3, lock released on 4.
        add_data(1, 0, 1'b0, 1'b1);
        add_data(1, 1, 1'b0, 1'b1);
        add_data(1, 3, 1'b1, 1'b1);
        add_data(1, 4, 1'b0, 1'b0);
        drain(40);

        // Source 3 locked, goes idle; ACK interleaves, source 0 stays blocked.
        add_data(3, 0, 1'b0, 1'b1);
        add_data(3, 1, 1'b0, 1'b1);
        drain(20);
        chk("lock_s3", locked, 1'b1);
        src_en[3] = 1'b0;
        add_ack(1'b1, 2'd3);
        for (int f = 2; f < 5; f++) add_data(3, f, 1'b0, f < 4);
        for (int f = 0; f < 5; f++) add_data(0, f, 1'b0, f < 4);
        repeat (3) begin
            step();
            chk("s0_blocked", req_ready[0], 1'b0);
        end
        src_en[3] = 1'b1;
        drain(40);

        // FIFO full for 4 cycles mid-packet; lock held, ACK stalled too.
        for (int f = 0; f < 5; f++) add_data(2, f, 1'b0, f < 4);
        step();
        step();
        full_r = 1'b1;
        add_ack(1'b0, 2'd2);
        repeat (4) step();
        chk("lock_during_full", locked, 1'b1);
        full_r = 1'b0;
        drain(40);

        // Reset while locked on source 2.
        add_data(2, 0, 1'b0, 1'b1);
        add_data(2, 1, 1'b0, 1'b1);
        drain(20);
        chk("lock_s2", locked, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", wr_tx_fifo, 1'b0);
        chk("mid_rst_frag", frag_tx, '0);
        chk("mid_rst_gid", grant_id, 2'd0);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_err", err_frag_seq, 1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prev_hs = 1'b0;
        for (int s = 0; s < NS; s++) begin
            for (int f = 0; f < 5; f++) add_data(s, f, 1'b0, f < 4);
        end
        drain(100);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule

// File: doc/frag_tx_arbiter.md
Name: frag_tx_arbiter

Overview:
- Sequences the shared Aurora TX fragment FIFO between NUM_SRC per-router segmenter lanes and one ACK generator.
- Each granted fragment is one 256-bit word. Header fields:
  - [1:0] src router
  - [3:2] dst router
  - [6:4] fragment number
  - [8:7] reserved
  - [255:9] payload
- It is the transmit-side counterpart of the receive reassembler. With LOCK_PKT=1 it keeps the fragments of one packet contiguous on the link. It also checks fragment-number ordering.

Parameters:
- AURORA_WIDTH, 256, fragment word width.
- NUM_SRC, 4, number of data requesters (router lanes), power of 2.
- SRC_ID_WIDTH, 2, log2(NUM_SRC).
- NUMBER_FRAG, 5, fragments per data packet; last fragment number = NUMBER_FRAG-1.
- LOCK_PKT, 1, 1 = hold grant for a whole packet; 0 = re-arbitrate every fragment.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_SRC  per-source fragment valid
- req_frag  in  NUM_SRC*AURORA_WIDTH  per-source fragment; source i at [i*AURORA_WIDTH +: AURORA_WIDTH]
- req_ready  out  NUM_SRC  per-source accept, combinational, at most one bit set
- ack_valid  in  1  ACK fragment valid
- ack_frag  in  AURORA_WIDTH  ACK fragment
- ack_ready  out  1  ACK accept, combinational
- full_tx_fifo  in  1  TX FIFO full
- wr_tx_fifo  out  1  TX FIFO write strobe, registered
- frag_tx  out  AURORA_WIDTH  fragment to TX FIFO, registered
- grant_id  out  SRC_ID_WIDTH  source of the last written data fragment, registered
- locked  out  1  packet lock held
- err_frag_seq  out  1  one-cycle pulse on fragment-order violation

Behaviour:
- Reset values:
  - wr_tx_fifo, frag_tx, grant_id, locked, err_frag_seq = 0.
  - Round-robin pointer = NUM_SRC-1, so source 0 wins first.
  - exp_frag = 0.
  - State = UNLOCKED.
- Reset asserted mid-packet drops the lock immediately; no partial-packet recovery.
- Transfer handshake: a transfer occurs in any cycle where valid & ready.
  - No ready is asserted while full_tx_fifo=1.
  - ready never depends on the requester's own data.
- Latency is 1 cycle. The cycle after an accept: wr_tx_fifo=1 and frag_tx = accepted word. Otherwise wr_tx_fifo=0 and frag_tx holds its last value.
- UNLOCKED state:
  - ack_valid has strict priority: ack_ready=1, all req_ready=0.
  - Else grant the first source with req_valid set, searching from pointer+1 with wrap modulo NUM_SRC.
  - On a data accept: pointer <= granted id; grant_id <= granted id.
  - If LOCK_PKT=1 and the fragment number != NUMBER_FRAG-1: go to LOCKED with lock_id = granted id, exp_frag = fnum+1.
- LOCKED state (LOCK_PKT=1 only):
  - Only lock_id may receive req_ready; other data sources are blocked.
  - If req_valid[lock_id]=0 and ack_valid=1, the ACK is accepted. This is legal interleaving because the receiver reassembles per source.
  - If both are valid, the data fragment wins, so the packet finishes first.
  - Each accepted fragment increments exp_frag.
  - Fragment number == NUMBER_FRAG-1 releases the lock: go to UNLOCKED, pointer = lock_id.
- Fragment-order check: err_frag_seq pulses (registered, same cycle as wr_tx_fifo) when an accepted fragment's number != exp_frag.
  - In UNLOCKED, exp_frag is 0.
  - The fragment is still forwarded; the lock state follows the received fragment number, not exp_frag.
  - A fragment number > NUMBER_FRAG-1 is flagged and treated as last.
- LOCK_PKT=0:
  - Never LOCKED; locked stays 0.
  - ACK priority and round-robin apply every cycle.
  - Order check still runs against a per-source expected counter that wraps to 0 after the last fragment.
- locked is registered and reflects the state.
- grant_id is unchanged by ACK transfers.
- full_tx_fifo rising mid-packet stalls all sources; the lock is held; ACK is also stalled.

Test Plan:
- Sources 0 and 2 both present 5-fragment packets (fnum 0..4), LOCK_PKT=1, FIFO never full -> 10 writes: all of source 0, then all of source 2; locked=1 during fragments 0..3 of each; err_frag_seq never 1.
- ack_valid asserted together with req_valid[1] while UNLOCKED -> the ACK is written first, then source 1 fragment 0; grant_id=1 after the data write.
- Source 3 locked after fragment 1, req_valid[3] drops 3 cycles, ack_valid=1, source 0 valid -> the ACK is written; source 0 is not granted; source 3 resumes at fnum 2.
- Source 1 sends fnum 0,1,3,4 -> err_frag_seq pulses on the fnum 3 write; lock releases after fnum 4.
- full_tx_fifo=1 for 4 cycles mid-packet -> no ready, no writes; the lock is held; the stream resumes with the correct next fragment.
- rst_n pulsed low while locked on source 2 -> all outputs 0 and locked=0; after release, source 0 wins the first grant when all sources are valid.
